// File: rtl/piso_serializer.sv
// Parametrised PISO shift register with a one-word holding buffer for gapless
// back-to-back streaming, valid/last-bit flags and a wrapping word counter.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic             READY,
  output logic             Q,
  output logic             Q_VALID,
  output logic             DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] WORD_CNT
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [BC_W-1:0]  bc;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;

  always_comb begin
    READY    = !hold_valid;
    accept   = LOAD && !hold_valid;
    last_bit = (state == ST_SHIFT) && (bc == BC_LAST);
    if (MSB_FIRST != 0) begin
      sr_shifted = {sr[WIDTH-2:0], 1'b0};
      Q          = (state == ST_SHIFT) && sr[WIDTH-1];
    end else begin
      sr_shifted = {1'b0, sr[WIDTH-1:1]};
      Q          = (state == ST_SHIFT) && sr[0];
    end
    Q_VALID = (state == ST_SHIFT);
    DONE    = last_bit;
    BUSY    = (state == ST_SHIFT) || hold_valid;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      sr         <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      bc         <= '0;
      WORD_CNT   <= '0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        sr    <= D;
        bc    <= '0;
        state <= ST_SHIFT;
      end
    end else if (!last_bit) begin
      sr <= sr_shifted;
      bc <= bc + BC_W'(1);
      if (accept) begin
        hold       <= D;
        hold_valid <= 1'b1;
      end
    end else begin
      // Last bit: refill from HOLD, else bypass a fresh load, else go idle.
      WORD_CNT <= WORD_CNT + CNT_W'(1);
      bc       <= '0;
      if (hold_valid) begin
        sr         <= hold;
        hold_valid <= 1'b0;
      end else if (accept) begin
        sr <= D;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four configurations checked every cycle against a
// word-queue reference model, with directed scenarios then random traffic.
module tb_piso_serializer;

  logic       CLK = 1'b0;
  logic       rst  [4];
  logic       load [4];
  logic [7:0] d    [4];
  logic       rdy  [4];
  logic       q    [4];
  logic       qv   [4];
  logic       dn   [4];
  logic       bs   [4];
  logic [7:0] wc   [3];
  logic [1:0] wc3;

  int wd   [4] = '{4, 4, 8, 2};
  int msbf [4] = '{1, 0, 1, 0};
  int cw   [4] = '{8, 8, 8, 2};

  // Reference model: up to two words queued, the head being emitted at bit pos.
  int         n   [4];
  int         pos [4];
  int         cnt [4];
  logic [7:0] w0  [4];
  logic [7:0] w1  [4];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .CNT_W(8)) u0 (
    .CLK(CLK), .RST(rst[0]), .LOAD(load[0]), .D(d[0][3:0]), .READY(rdy[0]), .Q(q[0]),
    .Q_VALID(qv[0]), .DONE(dn[0]), .BUSY(bs[0]), .WORD_CNT(wc[0]));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .CNT_W(8)) u1 (
    .CLK(CLK), .RST(rst[1]), .LOAD(load[1]), .D(d[1][3:0]), .READY(rdy[1]), .Q(q[1]),
    .Q_VALID(qv[1]), .DONE(dn[1]), .BUSY(bs[1]), .WORD_CNT(wc[1]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .CNT_W(8)) u2 (
    .CLK(CLK), .RST(rst[2]), .LOAD(load[2]), .D(d[2]), .READY(rdy[2]), .Q(q[2]),
    .Q_VALID(qv[2]), .DONE(dn[2]), .BUSY(bs[2]), .WORD_CNT(wc[2]));
  piso_serializer #(.WIDTH(2), .MSB_FIRST(0), .CNT_W(2)) u3 (
    .CLK(CLK), .RST(rst[3]), .LOAD(load[3]), .D(d[3][1:0]), .READY(rdy[3]), .Q(q[3]),
    .Q_VALID(qv[3]), .DONE(dn[3]), .BUSY(bs[3]), .WORD_CNT(wc3));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      logic       busy_e;
      logic       q_e;
      logic [7:0] wc_e;
      logic [7:0] wc_o;
      busy_e = (n[i] > 0);
      q_e    = 1'b0;
      if (busy_e) q_e = w0[i][(msbf[i] != 0) ? (wd[i] - 1 - pos[i]) : pos[i]];
      wc_e = 8'(cnt[i] % (1 << cw[i]));
      wc_o = (i == 3) ? {6'b0, wc3} : wc[i];
      chk($sformatf("ready%0d", i), {7'b0, rdy[i]}, {7'b0, (n[i] < 2)});
      chk($sformatf("q%0d", i), {7'b0, q[i]}, {7'b0, q_e});
      chk($sformatf("q_valid%0d", i), {7'b0, qv[i]}, {7'b0, busy_e});
      chk($sformatf("done%0d", i), {7'b0, dn[i]}, {7'b0, busy_e && (pos[i] == wd[i] - 1)});
      chk($sformatf("busy%0d", i), {7'b0, bs[i]}, {7'b0, busy_e});
      chk($sformatf("word_cnt%0d", i), wc_o, wc_e);
    end
  endtask

  task automatic update_model();
    for (int i = 0; i < 4; i++) begin
      logic       acc;
      logic [7:0] din;
      din = d[i] & 8'((1 << wd[i]) - 1);
      if (rst[i]) begin
        n[i] = 0; pos[i] = 0; cnt[i] = 0;
      end else begin
        acc = load[i] && (n[i] < 2);
        if (n[i] > 0) begin
          if (pos[i] == wd[i] - 1) begin
            cnt[i]++;
            w0[i] = w1[i];
            n[i]--;
            pos[i] = 0;
          end else begin
            pos[i]++;
          end
        end
        if (acc) begin
          if (n[i] == 0) begin
            w0[i] = din; n[i] = 1; pos[i] = 0;
          end else begin
            w1[i] = din; n[i] = 2;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    check_all();
    @(posedge CLK);
    update_model();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; load[i] = 1'b0; d[i] = '0;
      n[i] = 0; pos[i] = 0; cnt[i] = 0; w0[i] = '0; w1[i] = '0;
    end
    @(posedge CLK);
    update_model();
    #1;
    cycle();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    cycle();

    // Single word, both bit orders
    load[0] = 1'b1; d[0] = 8'hD;
    load[1] = 1'b1; d[1] = 8'hD;
    cycle();
    load[0] = 1'b0; load[1] = 1'b0;
    repeat (6) cycle();
    chk("t1_cnt", wc[0], 8'd1);
    chk("t1_q_idle", {7'b0, q[0]}, 8'd0);
    load[1] = 1'b1; d[1] = 8'h2;
    cycle();
    load[1] = 1'b0;
    repeat (6) cycle();
    chk("t2_cnt", wc[1], 8'd2);

    // Back-to-back through HOLD
    load[0] = 1'b1; d[0] = 8'hD;
    cycle();
    load[0] = 1'b0;
    cycle();
    load[0] = 1'b1; d[0] = 8'h2;
    cycle();
    load[0] = 1'b0;
    chk("b2b_ready", {7'b0, rdy[0]}, 8'd0);
    repeat (10) cycle();
    chk("b2b_cnt", wc[0], 8'd3);

    // Bypass load in the DONE cycle
    load[0] = 1'b1; d[0] = 8'hD;
    cycle();
    load[0] = 1'b0;
    repeat (3) cycle();
    chk("bypass_done", {7'b0, dn[0]}, 8'd1);
    load[0] = 1'b1; d[0] = 8'h2;
    cycle();
    load[0] = 1'b0;
    chk("bypass_ready", {7'b0, rdy[0]}, 8'd1);
    repeat (6) cycle();
    chk("bypass_cnt", wc[0], 8'd5);

    // Reset mid-word with a pending word
    load[2] = 1'b1; d[2] = 8'hA5;
    cycle();
    d[2] = 8'h3C;
    cycle();
    load[2] = 1'b0;
    cycle();
    rst[2] = 1'b1;
    cycle();
    rst[2] = 1'b0;
    chk("rst_busy", {7'b0, bs[2]}, 8'd0);
    repeat (12) cycle();
    chk("rst_cnt", wc[2], 8'd0);

    // Counter wrap with sustained streaming
    load[3] = 1'b1;
    repeat (11) begin
      d[3] = 8'($urandom);
      cycle();
    end
    load[3] = 1'b0;
    chk("wrap_cnt", {6'b0, wc3}, 8'd1);
    repeat (3) cycle();

    // Random traffic on all configurations
    repeat (600) begin
      for (int i = 0; i < 4; i++) begin
        load[i] = ($urandom_range(0, 2) != 0);
        d[i]    = 8'($urandom);
        rst[i]  = ($urandom_range(0, 59) == 0);
      end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      load[i] = 1'b0; rst[i] = 1'b0;
    end
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register; successor to the team's fixed 4-bit PISO.
- Adds configurable width and bit order, a load handshake, and a one-word holding buffer so that back-to-back words stream with no gap cycles.
- Adds valid/last-bit flags and a wrapping completed-word counter.
- Sits between parallel data sources and single-wire serial links.

Parameters:
- WIDTH, 8, parallel word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift out D[WIDTH-1] first; 0 = shift out D[0] first.
- CNT_W, 8, width of the completed-word counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- LOAD  in  1  load request, active-high; qualified by READY.
- D  in  WIDTH  parallel word; sampled on an accepted load.
- READY  out  1  block can accept a word this cycle.
- Q  out  1  serial data out.
- Q_VALID  out  1  Q carries a valid bit.
- DONE  out  1  Q carries the last bit of the current word.
- BUSY  out  1  block is shifting or holds a pending word.
- WORD_CNT  out  CNT_W  count of fully shifted words; wraps.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset state: SR=0, HOLD=0, HOLD_VALID=0, bit counter BC=0, FSM=IDLE, WORD_CNT=0.
- Reset outputs: Q=0, Q_VALID=0, DONE=0, BUSY=0, READY=1.
- RST has priority over LOAD. Reset mid-word aborts the current word and discards HOLD. WORD_CNT is not incremented for an aborted word.
- Accept rule: a load is accepted at an edge where LOAD=1 and READY=1. READY = !HOLD_VALID. LOAD with READY=0 is ignored; the source must hold it.
- FSM states: IDLE, SHIFT.
- IDLE, accepted load: SR<=D, BC<=0, go to SHIFT. The first bit appears on Q in the cycle after the accepting edge (latency 1).
- SHIFT outputs: Q = SR[WIDTH-1] if MSB_FIRST, else SR[0]; Q_VALID=1.
- SHIFT, BC<WIDTH-1 at an edge:
  - SR shifts toward the output end, filling with 0.
  - BC increments.
  - An accepted load writes HOLD<=D and sets HOLD_VALID=1.
- SHIFT, BC==WIDTH-1 (last bit) at an edge: WORD_CNT increments (mod 2^CNT_W), then exactly one of:
  - HOLD_VALID=1: SR<=HOLD, HOLD_VALID<=0, BC<=0, stay in SHIFT (seamless, no gap).
  - HOLD_VALID=0 and an accepted load: SR<=D directly (bypass), BC<=0, stay in SHIFT.
  - Otherwise: go to IDLE; Q=0, Q_VALID=0.
- DONE = (FSM==SHIFT) && (BC==WIDTH-1); combinational from registers; high for exactly one cycle per word.
- BUSY = (FSM==SHIFT) || HOLD_VALID.
- IDLE: Q=0, Q_VALID=0, DONE=0.
- Buffer full: HOLD_VALID=1 forces READY=0. READY returns to 1 in the cycle after HOLD moves into SR.
- Sustained streaming: with LOAD held high, throughput is one word per WIDTH cycles with Q_VALID continuously 1.
- BC width is clog2(WIDTH).
- D changes while a word is not being accepted have no effect.
- WORD_CNT wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- WIDTH=4, MSB_FIRST=1: reset, then LOAD=1 with D=4'b1101 for one cycle -> Q=1,1,0,1 on the next 4 cycles; Q_VALID high 4 cycles; DONE high on the 4th only; WORD_CNT=1; then IDLE with Q=0.
- WIDTH=4, MSB_FIRST=0, D=4'b1101 -> Q=1,0,1,1; then D=4'b0010 -> Q=0,1,0,0.
- Back-to-back, WIDTH=4: load 1101, then load 0010 on the 2nd shift cycle -> READY drops to 0 after the second accept; Q=1,1,0,1,0,0,1,0 with no gap; Q_VALID high 8 cycles; DONE pulses at cycles 4 and 8; WORD_CNT=2.
- Bypass, WIDTH=4: LOAD asserted only in the DONE cycle of word 1101 with D=4'b0010 -> 0010 streams with no gap; HOLD_VALID stays 0; READY stays 1.
- Reset mid-word, WIDTH=8: load 8'hA5 with a pending HOLD, assert RST on the 3rd bit -> next cycle all outputs at reset values; WORD_CNT=0; the pending word is never emitted.
- Counter wrap, CNT_W=2, WIDTH=2: stream 5 words -> WORD_CNT goes 1,2,3,0,1.
